// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling stream.
//   pool_mode_e : frame-wide pooling mode (MAX = 0, AVG = 1)
//   POS_*       : winning-pixel position within a 2x2 window
//   ADDR_W      : width of the linear output-index port
package pool_pkg;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    localparam logic [1:0] POS_TL = 2'd0;
    localparam logic [1:0] POS_TR = 2'd1;
    localparam logic [1:0] POS_BL = 2'd2;
    localparam logic [1:0] POS_BR = 2'd3;

    localparam int ADDR_W = 12;

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one partial result per horizontal pixel pair of an
// even row, read back while the matching odd row streams in.
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : pair index to write
//   i_wr_data : partial result to store
//   i_rd_addr : pair index to read
//   o_rd_data : stored partial result (combinational read)
module pool_line_buf #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 18,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the storage array has no reset; every entry is rewritten on an
    // even row before the odd row reads it, so stale contents never escape.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its sources.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 max / average pooling over a raster-order frame.
//   clk, rst_n      : clock, synchronous active-low reset
//   mode            : 0 = max, 1 = average; sampled on pixel (0,0) only
//   in_valid/ready  : pixel handshake, in_data is the pixel
//   out_valid/ready : result handshake
//   out_data        : pooled value
//   out_idx         : winning position (TL/TR/BL/BR), 0 in average mode
//   out_addr        : linear output index of the presented result
//   done            : pulses when the last result of a frame is accepted
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int HALF_W = IMG_W / 2;
    localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int LB_W   = DATA_W + 2;
    localparam int N_OUT  = HALF_W * (IMG_H / 2);

    if ((IMG_W % 2) != 0 || IMG_W < 2 || IMG_W > 64) begin : g_bad_img_w
        $error("pool2d_stream: IMG_W must be even and within 2..64");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2 || IMG_H > 64) begin : g_bad_img_h
        $error("pool2d_stream: IMG_H must be even and within 2..64");
    end

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    pool_mode_e        r_mode;
    logic [DATA_W-1:0] r_first;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_idx;
    logic [ADDR_W-1:0] r_addr;

    logic              w_accept;
    logic              w_lb_wr;
    logic              w_produce;
    logic              w_first_wins;
    logic              w_top_wins;
    logic [DATA_W-1:0] w_pair_max;
    logic [DATA_W:0]   w_pair_sum;
    logic [LB_W-1:0]   w_lb_wdata;
    logic [LB_W-1:0]   w_lb_rdata;
    logic [LB_W-1:0]   w_quad_sum;
    logic [LB_AW-1:0]  w_pair_idx;
    logic [DATA_W-1:0] w_res_data;
    logic [1:0]        w_res_idx;

    // Only a pending, unaccepted result can stall the input.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // The second pixel of each horizontal pair closes the pair: on even rows
    // it is parked in the line buffer, on odd rows it completes a window.
    assign w_lb_wr    = w_accept && r_col[0] && !r_row[0];
    assign w_produce  = w_accept && r_col[0] &&  r_row[0];
    assign w_pair_idx = LB_AW'(r_col >> 1);

    assign w_first_wins = r_first >= in_data;
    assign w_pair_max   = w_first_wins ? r_first : in_data;
    assign w_pair_sum   = {1'b0, r_first} + {1'b0, in_data};

    // Buffered entry layout: max mode {0, right_won, pair_max}, average mode
    // the zero-extended pair sum, so the quad sum can never overflow.
    assign w_top_wins = w_lb_rdata[DATA_W-1:0] >= w_pair_max;
    assign w_quad_sum = w_lb_rdata + LB_W'(w_pair_sum);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_lb_wdata = '0;
        w_res_data = '0;
        w_res_idx  = POS_TL;
        if (r_mode == MODE_AVG) begin
            w_lb_wdata = LB_W'(w_pair_sum);
            w_res_data = DATA_W'(w_quad_sum >> 2);
        end else begin
            w_lb_wdata = {1'b0, !w_first_wins, w_pair_max};
            // Top pair wins ties against the bottom pair: lower index first.
            if (w_top_wins) begin
                w_res_data = w_lb_rdata[DATA_W-1:0];
                w_res_idx  = w_lb_rdata[DATA_W] ? POS_TR : POS_TL;
            end else begin
                w_res_data = w_pair_max;
                w_res_idx  = w_first_wins ? POS_BL : POS_BR;
            end
        end
    end

    pool_line_buf #(
        .DEPTH (HALF_W),
        .WIDTH (LB_W),
        .AW    (LB_AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_wr),
        .i_wr_addr (w_pair_idx),
        .i_wr_data (w_lb_wdata),
        .i_rd_addr (w_pair_idx),
        .o_rd_data (w_lb_rdata)
    );

    // Pixel position, frame mode and the held first pixel of the pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_mode  <= MODE_MAX;
            r_first <= '0;
        end else if (w_accept) begin
            if (r_col == '0 && r_row == '0) begin
                r_mode <= pool_mode_e'(mode);
            end
            if (!r_col[0]) begin
                r_first <= in_data;
            end
            if (r_col == CW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Output register. A new result can only arrive while in_ready is high,
    // so loading it never overwrites an unaccepted one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_addr      <= '0;
        end else begin
            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res_data;
                r_out_idx   <= w_res_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && out_ready) begin
                r_addr <= (r_addr == ADDR_W'(N_OUT - 1)) ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_addr  = r_addr;
    assign done      = r_out_valid && out_ready && (r_addr == ADDR_W'(N_OUT - 1));

endmodule
